// File: rtl/mcpu_soc_pic.sv
// mcpu_soc_pic: edge-detecting, priority-encoding interrupt controller with a claim/complete handshake.
// Defining MCPU_SOC_PIC_LEVEL_EN adds per-line MODE registers selecting level-sensitive lines.
module mcpu_soc_pic #(
    parameter int NUM_PERIPHS = 1,
    parameter int LINES       = 32
) (
    input  logic                      clkrst_core_clk,
    input  logic                      clkrst_core_rst_n,
    input  logic [9:0]                addr,
    input  logic [31:0]               data_in,
    input  logic [31:0]               write_mask,
    output logic [31:0]               data_out,
    input  logic [32*NUM_PERIPHS-1:0] interrupt_trigger,
    output logic                      int_pending
);

    localparam logic [31:0] LINE_MASK = (LINES >= 32) ? 32'hFFFF_FFFF : ((32'h1 << LINES) - 32'h1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_e;

    state_e                    state_q;
    logic [9:0]                claimed_vec_q;
    logic                      int_pending_q;
    logic [32*NUM_PERIPHS-1:0] prev_q;
    logic [31:0]               pending_q [NUM_PERIPHS];
    logic [31:0]               pending_d [NUM_PERIPHS];
    logic [31:0]               enable_q  [NUM_PERIPHS];
    logic [31:0]               enable_d  [NUM_PERIPHS];
`ifdef MCPU_SOC_PIC_LEVEL_EN
    logic [31:0]               mode_q    [NUM_PERIPHS];
    logic [31:0]               mode_d    [NUM_PERIPHS];
`endif
    logic [31:0]               trig_s    [NUM_PERIPHS];
    logic [31:0]               clr_s     [NUM_PERIPHS];

    logic       wr_s;
    logic       valid_s;
    logic [9:0] vec_s;
    logic       claim_s;
    logic       complete_s;
    logic       next_idle_s;
    logic       any_next_s;
    logic [31:0] status_s;

    assign wr_s        = |write_mask;
    assign claim_s     = (state_q == ST_IDLE) && wr_s && (addr == 10'h001) && valid_s;
    assign complete_s  = (state_q == ST_SERVICE) && wr_s && (addr == 10'h002);
    assign next_idle_s = (state_q == ST_IDLE) ? !claim_s : complete_s;
    assign int_pending = int_pending_q;

    // Priority encoder: scan from the highest index down so the lowest active line is the last hit.
    always_comb begin
        valid_s = 1'b0;
        vec_s   = 10'd0;
        for (int p = NUM_PERIPHS - 1; p >= 0; p--) begin
            for (int l = 31; l >= 0; l--) begin
                valid_s = valid_s | (pending_q[p][l] & enable_q[p][l]);
                vec_s   = (pending_q[p][l] & enable_q[p][l]) ? {5'(p), 5'(l)} : vec_s;
            end
        end
    end

    // Next values of per-peripheral registers; a fresh rising edge wins over any clear in the same cycle.
    always_comb begin
        any_next_s = 1'b0;
        for (int p = 0; p < NUM_PERIPHS; p++) begin
            trig_s[p] = interrupt_trigger[32*p +: 32] & LINE_MASK;
            clr_s[p]  = ((wr_s && (addr == (10'h100 + 10'(p)))) ? (data_in & write_mask) : 32'h0)
                      | ((claim_s && (vec_s[9:5] == 5'(p))) ? (32'h1 << vec_s[4:0]) : 32'h0);
            pending_d[p] = (pending_q[p] & ~clr_s[p]) | (trig_s[p] & ~prev_q[32*p +: 32]);
            enable_d[p]  = (wr_s && (addr == (10'h200 + 10'(p))))
                         ? (((enable_q[p] & ~write_mask) | (data_in & write_mask)) & LINE_MASK)
                         : enable_q[p];
`ifdef MCPU_SOC_PIC_LEVEL_EN
            pending_d[p] = (pending_d[p] & ~mode_q[p]) | (trig_s[p] & mode_q[p]);
            mode_d[p]    = (wr_s && (addr == (10'h300 + 10'(p))))
                         ? (((mode_q[p] & ~write_mask) | (data_in & write_mask)) & LINE_MASK)
                         : mode_q[p];
`endif
            any_next_s = any_next_s | (|(pending_d[p] & enable_d[p]));
        end
    end

    // MMIO read mux: zero latency, out-of-range indices and unmapped words read zero.
    always_comb begin
        status_s = 32'h0;
        for (int p = 0; (p < NUM_PERIPHS) && (p < 31); p++) begin
            status_s[p] = |(pending_q[p] & enable_q[p]);
        end
        status_s[31] = (state_q == ST_SERVICE);
        data_out = 32'h0;
        case (addr[9:8])
            2'b00: begin
                case (addr[7:0])
                    8'h00:   data_out = status_s;
                    8'h01:   data_out = {valid_s, 21'h0, vec_s};
                    8'h02:   data_out = {(state_q == ST_SERVICE), 21'h0, claimed_vec_q};
                    default: data_out = 32'h0;
                endcase
            end
            2'b01: begin
                for (int p = 0; p < NUM_PERIPHS; p++) begin
                    data_out = (addr[7:0] == 8'(p)) ? pending_q[p] : data_out;
                end
            end
            2'b10: begin
                for (int p = 0; p < NUM_PERIPHS; p++) begin
                    data_out = (addr[7:0] == 8'(p)) ? enable_q[p] : data_out;
                end
            end
`ifdef MCPU_SOC_PIC_LEVEL_EN
            2'b11: begin
                for (int p = 0; p < NUM_PERIPHS; p++) begin
                    data_out = (addr[7:0] == 8'(p)) ? mode_q[p] : data_out;
                end
            end
`endif
            default: data_out = 32'h0;
        endcase
    end

    // Service FSM, edge history, line registers and the registered request to the core.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            state_q       <= ST_IDLE;
            claimed_vec_q <= 10'd0;
            int_pending_q <= 1'b0;
            prev_q        <= {(32*NUM_PERIPHS){1'b0}};
            for (int p = 0; p < NUM_PERIPHS; p++) begin
                pending_q[p] <= 32'h0;
                enable_q[p]  <= 32'h0;
`ifdef MCPU_SOC_PIC_LEVEL_EN
                mode_q[p]    <= 32'h0;
`endif
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (claim_s) begin
                        state_q       <= ST_SERVICE;
                        claimed_vec_q <= vec_s;
                    end
                end
                ST_SERVICE: begin
                    if (complete_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            prev_q        <= interrupt_trigger;
            int_pending_q <= next_idle_s & any_next_s;
            for (int p = 0; p < NUM_PERIPHS; p++) begin
                pending_q[p] <= pending_d[p];
                enable_q[p]  <= enable_d[p];
`ifdef MCPU_SOC_PIC_LEVEL_EN
                mode_q[p]    <= mode_d[p];
`endif
            end
        end
    end

endmodule

// File: tb/tb_mcpu_soc_pic.sv
// Bench for mcpu_soc_pic: two instances (4x32 lines and 2x8 lines) share one stimulus stream and are
// compared every cycle against a behavioural model of the controller.
module tb_mcpu_soc_pic;

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [9:0]   addr;
    logic [31:0]  din;
    logic [31:0]  wm;
    logic [127:0] trig;
    logic [31:0]  dout0, dout1;
    logic         ip0, ip1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mcpu_soc_pic #(.NUM_PERIPHS(4), .LINES(32)) u_dut0 (
        .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n), .addr(addr), .data_in(din),
        .write_mask(wm), .data_out(dout0), .interrupt_trigger(trig), .int_pending(ip0)
    );

    mcpu_soc_pic #(.NUM_PERIPHS(2), .LINES(8)) u_dut1 (
        .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n), .addr(addr), .data_in(din),
        .write_mask(wm), .data_out(dout1), .interrupt_trigger(trig[63:0]), .int_pending(ip1)
    );

    // Reference model state, one set per instance.
    logic [31:0]  m_pend [2][4];
    logic [31:0]  m_en   [2][4];
    logic [31:0]  m_mode [2][4];
    logic [127:0] m_prev [2];
    bit           m_srv  [2];
    logic [9:0]   m_cvec [2];
    bit           m_intp [2];

    function automatic int np_of(int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic logic [31:0] lmask(int d);
        return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    task automatic chk_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 4; p++) begin
                m_pend[d][p] = 32'h0;
                m_en[d][p]   = 32'h0;
                m_mode[d][p] = 32'h0;
            end
            m_prev[d] = 128'h0;
            m_srv[d]  = 1'b0;
            m_cvec[d] = 10'h0;
            m_intp[d] = 1'b0;
        end
    endfunction

    function automatic void m_best(int d, output bit v, output logic [9:0] vec);
        v   = 1'b0;
        vec = 10'h0;
        for (int p = 0; p < np_of(d); p++) begin
            for (int l = 0; l < 32; l++) begin
                if (!v && m_pend[d][p][l] && m_en[d][p][l]) begin
                    v   = 1'b1;
                    vec = 10'((p * 32) + l);
                end
            end
        end
    endfunction

    function automatic logic [31:0] m_read(int d, logic [9:0] a);
        bit          v;
        logic [9:0]  vec;
        logic [31:0] r   = 32'h0;
        int          idx = int'(a[7:0]);
        m_best(d, v, vec);
        if (a == 10'h000) begin
            for (int p = 0; p < np_of(d); p++) r[p] = |(m_pend[d][p] & m_en[d][p]);
            r[31] = m_srv[d];
        end else if (a == 10'h001) begin
            r = {v, 21'h0, vec};
        end else if (a == 10'h002) begin
            r = {m_srv[d], 21'h0, m_cvec[d]};
        end else if (idx < np_of(d)) begin
            if (a[9:8] == 2'd1) r = m_pend[d][idx];
            else if (a[9:8] == 2'd2) r = m_en[d][idx];
`ifdef MCPU_SOC_PIC_LEVEL_EN
            else if (a[9:8] == 2'd3) r = m_mode[d][idx];
`endif
        end
        return r;
    endfunction

    function automatic void m_step(int d, logic [9:0] a, logic [31:0] dd, logic [31:0] m, logic [127:0] t);
        bit          v;
        logic [9:0]  vec;
        bit          wr = (m != 32'h0);
        bit          claim, comp, any;
        logic [31:0] mk = lmask(d);
        logic [31:0] tr, clr;
        logic [31:0] np_ [4];
        logic [31:0] ne_ [4];
        logic [31:0] nm_ [4];
        m_best(d, v, vec);
        claim = !m_srv[d] && wr && (a == 10'h001) && v;
        comp  = m_srv[d] && wr && (a == 10'h002);
        any   = 1'b0;
        for (int p = 0; p < np_of(d); p++) begin
            tr  = t[32*p +: 32] & mk;
            clr = 32'h0;
            if (wr && (a == 10'(256 + p))) clr = dd & m;
            if (claim && (int'(vec[9:5]) == p)) clr[vec[4:0]] = 1'b1;
            np_[p] = (m_pend[d][p] & ~clr) | (tr & ~m_prev[d][32*p +: 32]);
            ne_[p] = m_en[d][p];
            if (wr && (a == 10'(512 + p))) ne_[p] = ((ne_[p] & ~m) | (dd & m)) & mk;
            nm_[p] = m_mode[d][p];
`ifdef MCPU_SOC_PIC_LEVEL_EN
            np_[p] = (np_[p] & ~m_mode[d][p]) | (tr & m_mode[d][p]);
            if (wr && (a == 10'(768 + p))) nm_[p] = ((nm_[p] & ~m) | (dd & m)) & mk;
`endif
            any = any | (|(np_[p] & ne_[p]));
        end
        for (int p = 0; p < np_of(d); p++) begin
            m_pend[d][p] = np_[p];
            m_en[d][p]   = ne_[p];
            m_mode[d][p] = nm_[p];
        end
        m_prev[d] = t;
        if (claim) begin
            m_srv[d]  = 1'b1;
            m_cvec[d] = vec;
        end else if (comp) begin
            m_srv[d] = 1'b0;
        end
        m_intp[d] = !m_srv[d] && any;
    endfunction

    // One bus cycle: drive at the falling edge, check the read, then check the request after the rising edge.
    task automatic cyc(logic [9:0] a, logic [31:0] dd, logic [31:0] m, logic [127:0] t);
        @(negedge clk);
        addr = a; din = dd; wm = m; trig = t;
        #1;
        chk_eq($sformatf("rd0@%03h", a), dout0, m_read(0, a));
        chk_eq($sformatf("rd1@%03h", a), dout1, m_read(1, a));
        @(posedge clk);
        m_step(0, a, dd, m, t);
        m_step(1, a, dd, m, t);
        #1;
        chk_eq("irq0", {31'h0, ip0}, {31'h0, m_intp[0]});
        chk_eq("irq1", {31'h0, ip1}, {31'h0, m_intp[1]});
    endtask

    task automatic peek(logic [9:0] a);
        wm   = 32'h0;
        addr = a;
        #1;
        chk_eq($sformatf("peek0@%03h", a), dout0, m_read(0, a));
        chk_eq($sformatf("peek1@%03h", a), dout1, m_read(1, a));
    endtask

    logic [127:0] rt;
    logic [9:0]   ra;
    logic [31:0]  rm;
    int           rk;

    initial begin
        rst_n = 1'b0; addr = 10'h0; din = 32'h0; wm = 32'h0; trig = 128'h1;
        m_reset();
        #12;
        chk_eq("rst_irq0", {31'h0, ip0}, 32'h0);
        chk_eq("rst_irq1", {31'h0, ip1}, 32'h0);
        chk_eq("rst_status0", dout0, 32'h0);
        #4 rst_n = 1'b1;

        // Line held high through reset release.
        cyc(10'h000, 32'h0, 32'h0, 128'h1);
        peek(10'h100);
        chk_eq("tp_pend0", dout0, 32'h1);
        cyc(10'h200, 32'h1, ALL, 128'h1);
        chk_eq("tp_irq_en", {31'h0, ip0}, 32'h1);
        peek(10'h001);
        chk_eq("tp_claim0", dout0, 32'h8000_0000);
        cyc(10'h001, 32'h0, 32'h1, 128'h1);
        cyc(10'h002, 32'h0, 32'h1, 128'h1);
        cyc(10'h000, 32'h0, 32'h0, 128'h0);

        for (int p = 0; p < 4; p++) cyc(10'(512 + p), ALL, ALL, 128'h0);
        peek(10'h200);
        chk_eq("tp_en_lines8", dout1, 32'h0000_00FF);

        // Two simultaneous pulses, then claim/complete.
        cyc(10'h000, 32'h0, 32'h0, (128'h1 << 101) | (128'h1 << 41));
        cyc(10'h000, 32'h0, 32'h0, 128'h0);
        peek(10'h001);
        chk_eq("tp_claim29", dout0, 32'h8000_0029);
        cyc(10'h001, 32'h0, 32'h1, 128'h0);
        chk_eq("tp_irq_claim", {31'h0, ip0}, 32'h0);
        peek(10'h101);
        chk_eq("tp_pend1", dout0, 32'h0);
        cyc(10'h001, 32'h0, 32'h1, 128'h0);
        peek(10'h002);
        chk_eq("tp_cvec_hold", dout0, 32'h8000_0029);
        cyc(10'h002, 32'h0, 32'h1, 128'h0);
        chk_eq("tp_irq_complete", {31'h0, ip0}, 32'h1);
        peek(10'h001);
        chk_eq("tp_claim65", dout0, 32'h8000_0065);
        cyc(10'h002, 32'h0, 32'h1, 128'h0);
        peek(10'h000);
        chk_eq("tp_status_idle", dout0, 32'h0000_0008);

        // New edge in the same cycle as its W1C keeps the bit; W1C alone clears it.
        cyc(10'h103, 32'h20, ALL, 128'h1 << 101);
        peek(10'h103);
        chk_eq("tp_w1c_collide", dout0, 32'h20);
        cyc(10'h103, 32'h20, ALL, 128'h1 << 101);
        peek(10'h103);
        chk_eq("tp_w1c_clear", dout0, 32'h0);
        cyc(10'h000, 32'h0, 32'h0, 128'h0);

        // Lines above LINES never pend on the narrow instance.
        cyc(10'h000, 32'h0, 32'h0, 128'hFFFF_FF00);
        peek(10'h100);
        chk_eq("tp_hi_lines1", dout1, 32'h0);
        chk_eq("tp_hi_lines0", dout0, 32'hFFFF_FF00);
        cyc(10'h100, ALL, ALL, 128'hFFFF_FF00);
        cyc(10'h000, 32'h0, 32'h0, 128'h0);

`ifdef MCPU_SOC_PIC_LEVEL_EN
        cyc(10'h300, 32'h1, ALL, 128'h0);
        cyc(10'h000, 32'h0, 32'h0, 128'h1);
        cyc(10'h100, 32'h1, ALL, 128'h1);
        peek(10'h100);
        chk_eq("lvl_w1c", dout0 & 32'h1, 32'h1);
        cyc(10'h000, 32'h0, 32'h0, 128'h0);
        peek(10'h100);
        chk_eq("lvl_drop", dout0 & 32'h1, 32'h0);
        cyc(10'h300, 32'h0, ALL, 128'h0);
`endif

        // Randomised traffic against the model.
        rt = 128'h0;
        for (int i = 0; i < 800; i++) begin
            rk = $urandom_range(0, 4);
            case ($urandom_range(0, 11))
                0:       ra = 10'h000;
                1, 2, 3: ra = 10'h001;
                4, 5:    ra = 10'h002;
                6, 7:    ra = 10'(256 + rk);
                8, 9:    ra = 10'(512 + rk);
                10:      ra = 10'(768 + rk);
                default: ra = 10'($urandom);
            endcase
            rm = ($urandom_range(0, 3) == 0) ? 32'h0 : (($urandom_range(0, 1) == 1) ? ALL : $urandom);
            rt = rt ^ {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom,
                       $urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
            cyc(ra, $urandom, rm, rt);
        end

        // Asynchronous reset while in service.
        cyc(10'h002, 32'h0, 32'h1, 128'h0);
        cyc(10'h200, 32'h1, ALL, 128'h0);
        cyc(10'h000, 32'h0, 32'h0, 128'h1);
        cyc(10'h001, 32'h0, 32'h1, 128'h1);
        peek(10'h000);
        chk_eq("svc_bit", {31'h0, dout0[31]}, 32'h1);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk_eq("rst_mid_irq", {31'h0, ip0}, 32'h0);
        peek(10'h002);
        chk_eq("rst_mid_cvec", dout0, 32'h0);
        rst_n = 1'b1;
        cyc(10'h000, 32'h0, 32'h0, 128'h1);
        cyc(10'h200, 32'h1, ALL, 128'h1);
        chk_eq("post_rst_irq", {31'h0, ip0}, 32'h1);
        cyc(10'h001, 32'h0, 32'h0, 128'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mcpu_soc_pic.md
# mcpu_soc_pic

Parametrised interrupt controller for the MCPU SoC MMIO bus. It aggregates up to 32 peripherals with up to 32 interrupt lines each, and edge-detects every line. It priority-encodes pending and enabled lines into a vector, and enforces a claim/complete service handshake so the core sees one interrupt at a time. It sits between the peripheral interrupt outputs and the core's global interrupt input.

## Interface
- NUM_PERIPHS, 1: peripheral count, legal 1..32.
- LINES, 32: interrupt lines per peripheral, legal 1..32.
- clkrst_core_clk  in  1  core clock; all state updates on its rising edge.
- clkrst_core_rst_n  in  1  reset, asynchronous, active-low.
- addr  in  10  MMIO word address.
- data_in  in  32  MMIO write data.
- write_mask  in  32  per-bit write enable; all-zero means no write this cycle.
- data_out  out  32  MMIO read data, combinational from addr and state.
- interrupt_trigger  in  32*NUM_PERIPHS  peripheral p's line l is at bit 32*p+l; bits l>=LINES are ignored.
- int_pending  out  1  registered request to the core; 0 in reset.

## Operation
- Register map: 0x000 STATUS; 0x001 CLAIM; 0x002 COMPLETE; 0x100+p PENDING[p]; 0x200+p ENABLE[p]; 0x300+p MODE[p] (only with the macro).
- Unmapped addresses read 0, and writes to them are ignored.
- Bits l>=LINES and indices p>=NUM_PERIPHS read 0, and writes to them are ignored.
- STATUS read: bit p = |(PENDING[p]&ENABLE[p]) for p<31; bit 31 = in_service.
- ENABLE[p]: masked write, (old & ~write_mask) | (data_in & write_mask).
- PENDING[p]: write-1-to-clear, old & ~(data_in & write_mask).
- Edge detection: a prev register holds last cycle's triggers. A 0->1 transition sets the pending bit.
- Priority: lowest peripheral index first, then lowest line index.
- Vector: {periph[4:0], line[4:0]} of the highest-priority line with pending & enable set.
- CLAIM read: {valid, 21'b0, vector}; valid = 1 when a pending & enabled line exists.
- State machine IDLE/SERVICE, with in_service = (state == SERVICE).
- In IDLE, a CLAIM write (write_mask != 0) with valid = 1 does three things:
  - latches the vector into claimed_vec;
  - clears that line's pending bit;
  - moves the state to SERVICE.
- In IDLE, a CLAIM write with valid = 0 has no effect.
- In SERVICE, a COMPLETE write (write_mask != 0) moves the state to IDLE. The data value is ignored.
- In SERVICE, CLAIM writes are ignored. In IDLE, COMPLETE writes are ignored.
- claimed_vec reads at COMPLETE address: {in_service, 21'b0, claimed_vec}.
- int_pending is registered from next-cycle values: next_state == IDLE && |(next_PENDING & next_ENABLE) over all peripherals.

## Timing
- Reset values: all PENDING, ENABLE and MODE = 0; prev = 0; state = IDLE; claimed_vec = 0; int_pending = 0.
- Because prev resets to 0, a line held high through reset release sets pending at the first edge.
- Trigger edge present before edge k (prev=0, in=1): pending is set and int_pending is high after edge k, provided the line is enabled.
- A CLAIM write sampled at edge k makes int_pending low after edge k.
- A COMPLETE write sampled at edge k: int_pending is high after edge k if another enabled line is pending.
- Enabling an already-pending line at edge k makes int_pending high after edge k (when the state is IDLE).
- When a new edge coincides with a W1C or claim clear of the same bit, the set wins and the bit stays pending.
- Reset mid-SERVICE: asynchronous return to all reset values; no completion is required afterwards.
- data_out has zero latency and reflects state after the most recent edge.

## Configuration
- MCPU_SOC_PIC_LEVEL_EN defined:
  - MODE[p] exists as a masked-write register; bit = 1 selects level mode for that line.
  - A level-mode pending bit equals the registered trigger level.
  - W1C and claim do not clear a level-mode bit; it clears only when the source drops, one edge after.
- MCPU_SOC_PIC_LEVEL_EN undefined:
  - No MODE storage; 0x300+p reads 0 and writes are ignored.
  - All lines are edge-triggered.

## Test plan
- Reset with trigger bit 0 high, then ENABLE[0]=1 -> PENDING[0]=0x1; int_pending=1 one edge after the enable write; CLAIM reads 0x80000000.
- NUM_PERIPHS=4: pulse periph 3 line 5 and periph 1 line 9 in the same cycle, all enabled -> CLAIM reads 0x80000029. Claim -> int_pending=0, PENDING[1]=0. COMPLETE -> int_pending=1 next edge, CLAIM reads 0x80000065.
- A new edge on a line in the same cycle as its W1C -> the bit remains 1.
- In SERVICE: a second CLAIM write -> claimed_vec unchanged. COMPLETE in IDLE -> no state change.
- LINES=8: write 0xFFFFFFFF to ENABLE[0] -> reads 0x000000FF. Edges on bits 8..31 -> never pending.
- With MCPU_SOC_PIC_LEVEL_EN and MODE[0]=0x1, line held high: W1C leaves PENDING[0]=1; line drops -> PENDING[0]=0 after one edge.
